demux_1x4_sched: RTL

//  Sequencer for the 1x4 demultiplexer datapath. Accepts a word stream with a valid/ready handshake,

---
 rtl/demux_1x4_sched.sv | 114 +++++++++++
 1 files changed

// File: rtl/demux_1x4_sched.sv
// Sequencer for a 1x4 demultiplexer: holds one word from a valid/ready stream and steers it
// to one of four lanes, either round-robin in bursts (with stall timeout) or to a fixed lane.
module demux_1x4_sched #(
    parameter int WIDTH   = 8,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic [1:0]       fixed_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready,
    output logic             s1,
    output logic             s0,
    output logic             skip,
    output logic             busy
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_tgt;
    logic [1:0]       r_rr_ptr;
    logic [BW-1:0]    r_burst_cnt;
    logic [SW-1:0]    r_stall_cnt;
    logic             r_held_rr;
    logic             r_skip;

    logic w_full;
    logic w_tgt_ready;
    logic w_fire;
    logic w_load;
    logic w_timeout;

    assign w_full      = (r_state == S_FULL);
    assign w_tgt_ready = y_ready[r_tgt];
    assign w_fire      = w_full & w_tgt_ready;
    // rst_n gates ready so nothing is accepted while reset is held
    assign din_ready   = rst_n & enable & (~w_full | w_fire);
    assign w_load      = din_valid & din_ready;
    // Timeout applies only to words that were loaded in round-robin mode
    assign w_timeout   = w_full & r_held_rr & ~w_tgt_ready & (r_stall_cnt == STALL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_y         <= '0;
            r_tgt       <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_burst_cnt <= '0;
            r_stall_cnt <= '0;
            r_held_rr   <= 1'b0;
            r_skip      <= 1'b0;
        end else begin
            r_skip <= 1'b0;
            if (w_load) begin
                r_state     <= S_FULL;
                r_y         <= din;
                r_stall_cnt <= '0;
                r_held_rr   <= ~mode;
                if (!mode) begin
                    r_tgt <= r_rr_ptr;
                    if (r_burst_cnt == BURST_LAST) begin
                        r_burst_cnt <= '0;
                        r_rr_ptr    <= r_rr_ptr + 2'd1;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                    end
                end else begin
                    r_tgt <= fixed_sel;
                end
            end else if (w_fire) begin
                r_state     <= S_EMPTY;
                r_stall_cnt <= '0;
            end else if (w_timeout) begin
                r_tgt       <= r_tgt + 2'd1;
                r_stall_cnt <= '0;
                r_skip      <= 1'b1;
            end else if (w_full) begin
                r_stall_cnt <= r_stall_cnt + SW'(1);
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_valid
            assign y_valid[gi] = w_full & (r_tgt == 2'(gi));
        end
    endgenerate

    assign y    = r_y;
    assign s1   = r_tgt[1];
    assign s0   = r_tgt[0];
    assign skip = r_skip;
    assign busy = w_full;

endmodule
